// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared definitions for the Y86 memory subsystem: instruction
//               memory depth, address width, loader state encoding and the
//               loader error cause codes.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // One depth constant shared by the instruction memory and its loader.
    localparam int IMEM_BYTES = 132;

    // Byte address width; matches the PC width.
    localparam int ADDR_W = 64;

    // Loader error cause codes.
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } ld_state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Bundle between the boot/test byte source, the loader and the
//               instruction memory write port.
//   start      : one-cycle load request
//   in_valid   : source byte valid       in_data  : source byte
//   in_ready   : loader accepts a byte
//   wr_en/wr_addr/wr_data : byte-wide memory write port
//   busy       : load in progress (fetch held)
//   done/load_error/err_code : sticky load status
//   byte_count : payload bytes written in current/last load
//   Modports: slave = loader view, master = source/harness view.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              done;
    logic              load_error;
    logic [1:0]        err_code;
    logic [15:0]       byte_count;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data,
               busy, done, load_error, err_code, byte_count
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data,
               busy, done, load_error, err_code, byte_count
    );

endinterface : imem_loader_if
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Instruction memory writer. Accepts a framed byte stream
//               (2-byte little-endian length L, L payload bytes, XOR checksum
//               of the payload) and issues one registered byte write per
//               payload byte. Holds the processor off via busy while loading
//               and reports sticky done / load_error with a cause code.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : imem_loader_if.slave (stream in, write port out, status out)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = IMEM_BYTES,
    parameter int BASE_ADDR = 0
) (
    input  wire logic      clk,
    input  wire logic      rst,
    imem_loader_if.slave   bus
);

    ld_state_t         r_state;
    logic [15:0]       r_len;
    logic [7:0]        r_acc;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_done;
    logic              r_load_error;
    logic [1:0]        r_err_code;
    logic [15:0]       r_byte_count;

    logic              w_xfer;
    logic [15:0]       w_len_new;
    logic [16:0]       w_len_end;

    assign w_xfer    = bus.in_valid && r_in_ready;
    // Length as it becomes once the high byte in flight is captured.
    assign w_len_new = {bus.in_data, r_len[7:0]};
    // 17-bit end address so a large length cannot wrap past the compare.
    assign w_len_end = 17'(BASE_ADDR) + {1'b0, w_len_new};

    // in_ready/busy are registered alongside the state so they are set on
    // every transition into or out of the streaming states.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len        <= 16'd0;
            r_acc        <= 8'd0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= ADDR_W'(BASE_ADDR);
            r_wr_data    <= 8'd0;
            r_done       <= 1'b0;
            r_load_error <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_byte_count <= 16'd0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (bus.start) begin
                        r_state      <= S_LEN_LO;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_load_error <= 1'b0;
                        r_err_code   <= ERR_NONE;
                        r_byte_count <= 16'd0;
                        r_acc        <= 8'd0;
                        r_wr_addr    <= ADDR_W'(BASE_ADDR);
                    end
                end
                S_LEN_LO: begin
                    if (w_xfer) begin
                        r_len[7:0] <= bus.in_data;
                        r_state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_len[15:8] <= bus.in_data;
                        if (w_len_end > 17'(MEM_BYTES)) begin
                            r_state      <= S_ERROR;
                            r_in_ready   <= 1'b0;
                            r_busy       <= 1'b0;
                            r_load_error <= 1'b1;
                            r_err_code   <= ERR_OVF;
                        end else if (w_len_new == 16'd0) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_wr_en      <= 1'b1;
                        r_wr_data    <= bus.in_data;
                        r_wr_addr    <= ADDR_W'(BASE_ADDR) + ADDR_W'(r_byte_count);
                        r_byte_count <= r_byte_count + 16'd1;
                        r_acc        <= r_acc ^ bus.in_data;
                        if (r_byte_count + 16'd1 == r_len) begin
                            r_state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        if (bus.in_data == r_acc) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= S_ERROR;
                            r_load_error <= 1'b1;
                            r_err_code   <= ERR_CSUM;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.busy       = r_busy;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.done       = r_done;
    assign bus.load_error = r_load_error;
    assign bus.err_code   = r_err_code;
    assign bus.byte_count = r_byte_count;

endmodule : imem_loader
`default_nettype wire
